pes_cmp_sweep_checker: RTL and testbench
========================================

Name: pes_cmp_sweep_checker

Overview:
- Synthesizable driver/checker that sits on the operand side of the pes comparator.
- Drives A/B operand pairs into a comparator instance and samples its lt/eq/gt flags.
- Checks the flags against an internal golden model and reports a pass/fail verdict and an error count.
- Used for on-chip self-test and as the reusable stimulus/response end of the comparator interface.

Parameters:
- WIDTH, 2, operand width in bits; sweep index range is 0..2^WIDTH-1.
- SETTLE, 2, cycles to wait after driving operands before sampling flags (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse; begins a sweep when idle.
- a_o  output  WIDTH  operand A to comparator.
- b_o  output  WIDTH  operand B to comparator.
- lt_i  input  1  comparator A_less_B.
- eq_i  input  1  comparator A_equal_B.
- gt_i  input  1  comparator A_greater_B.
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse when the sweep completes.
- pass  output  1  verdict of the last completed sweep (err_cnt==0).
- err_cnt  output  CW  failing vector count, where CW = $clog2(3*2^WIDTH+1).

Behaviour:
- Reset (async, rst_n=0): state IDLE; a_o=0, b_o=0, busy=0, done=0, pass=0, err_cnt=0; all counters cleared.
- Three phases, each with i = 0..2^WIDTH-1:
  - LESS: A=i, B=i+1.
  - EQUAL: A=i, B=i.
  - GREATER: A=i+1, B=i.
- Total vectors: 3*2^WIDTH (12 at the default WIDTH).
- Arithmetic: i+1 is truncated to WIDTH bits, so it wraps. At WIDTH=2: LESS i=3 drives A=3,B=0; GREATER i=3 drives A=0,B=3.
- Expected flags are computed from the truncated operand values actually driven, never from the phase name.
- FSM states:
  - IDLE: start=1 -> DRIVE, clear err_cnt, set busy=1.
  - DRIVE (1 cycle): register a_o/b_o for the current vector -> SETTLE.
  - SETTLE (SETTLE cycles, down-counter) -> CHECK.
  - CHECK (1 cycle): compare {lt_i,eq_i,gt_i} with expected. Any mismatch, including non-one-hot or all-zero flags, increments err_cnt.
    - Not the last vector -> DRIVE with the index advanced.
    - Last vector -> DONE.
  - DONE (1 cycle): done=1, pass=(err_cnt==0), busy=0 -> IDLE.
- Timing: each vector takes 2+SETTLE cycles. done asserts 3*2^WIDTH*(2+SETTLE)+1 cycles after the start edge.
- a_o/b_o hold their value from DRIVE through CHECK.
- start while busy: ignored, no restart.
- start in the same cycle as done: ignored; a new sweep needs start while in IDLE.
- err_cnt saturates at its maximum, which cannot actually be exceeded with the chosen CW.
- Reset mid-sweep: immediate return to reset values; pass is cleared.
- pass and err_cnt hold their values in IDLE until the next start.

Optional Feature:
- Macro: PES_CMP_FIRST_FAIL_EN.
- Defined: adds outputs ff_valid (1), ff_a (WIDTH), ff_b (WIDTH), ff_flags (3).
  - On the first mismatch of a sweep, these capture the driven operands and the observed flags, and ff_valid is set.
  - Later failures in the same sweep do not overwrite the capture.
  - All four outputs are cleared on start and on reset.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package pes_cmp_pkg:
  - State encoding: IDLE, DRIVE, SETTLE, CHECK, DONE.
  - Phase encoding: LESS, EQUAL, GREATER.
  - Flag-vector index constants: LT=2, EQ=1, GT=0.
- Sub-module pes_cmp_golden: combinational WIDTH-parameterised reference that maps (a,b) to the expected one-hot {lt,eq,gt}. It is instantiated once in the checker.

Test Plan:
- Correct comparator, WIDTH=2, SETTLE=2, start pulse -> done after 49 cycles; pass=1, err_cnt=0; a_o/b_o sequence matches the 12 vectors, including the wrapped LESS i=3 vector (A=3, B=0, expected gt).
- Comparator with eq stuck at 1 (lt=gt=0) -> err_cnt=8, pass=0.
- Comparator with lt and gt swapped -> err_cnt=8, pass=0; EQUAL phase contributes 0 errors.
- rst_n pulled low during vector 5 -> all outputs return to reset values asynchronously; a new start gives a clean full sweep with pass=1.
- start re-pulsed at cycles 10 and 30 of a sweep -> ignored; done occurs exactly once, at cycle 49.
- With PES_CMP_FIRST_FAIL_EN, eq stuck at 1 -> ff_valid=1, ff_a=0, ff_b=1, ff_flags=3'b010.

Source files
------------

// File: rtl/pes_cmp_sweep_checker_pkg.sv
// ---------------------------------------------------------------------------
// pes_cmp_pkg: shared state/phase encodings and flag-vector indices for the checker
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pes_cmp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    LESS    = 2'd0,
    EQUAL   = 2'd1,
    GREATER = 2'd2
  } phase_e;

  localparam int LT = 2;
  localparam int EQ = 1;
  localparam int GT = 0;

  // Error counter width: enough to hold 3*2^WIDTH failures without saturating
  function automatic int calc_cw(input int width);
    return $clog2(3 * (2 ** width) + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pes_cmp_sweep_checker_if.sv
// ---------------------------------------------------------------------------
// pes_cmp_sweep_checker_if: operand/flag link between checker (master) and comparator (slave)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pes_cmp_sweep_checker_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] a_o;
  logic [WIDTH-1:0] b_o;
  logic             lt_i;
  logic             eq_i;
  logic             gt_i;

  modport master (output a_o, b_o, input lt_i, eq_i, gt_i);
  modport slave  (input a_o, b_o, output lt_i, eq_i, gt_i);
endinterface

`default_nettype wire

// File: rtl/pes_cmp_sweep_checker_golden.sv
// ---------------------------------------------------------------------------
// pes_cmp_golden: combinational reference mapping (a,b) to one-hot {lt,eq,gt}
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pes_cmp_golden
  import pes_cmp_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       flags
);

  always_comb begin
    flags     = 3'b000;
    flags[LT] = (a < b);
    flags[EQ] = (a == b);
    flags[GT] = (a > b);
  end

endmodule

`default_nettype wire

// File: rtl/pes_cmp_sweep_checker.sv
// ---------------------------------------------------------------------------
// pes_cmp_sweep_checker: sweeps LESS/EQUAL/GREATER operand pairs into a comparator
// and checks its flags. Optional first-fail capture: PES_CMP_FIRST_FAIL_EN. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pes_cmp_sweep_checker
  import pes_cmp_pkg::*;
#(
  parameter  int WIDTH  = 2,
  parameter  int SETTLE = 2,
  localparam int CW     = calc_cw(WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  pes_cmp_sweep_checker_if.master  cmp,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [CW-1:0]            err_cnt
`ifdef PES_CMP_FIRST_FAIL_EN
  ,
  output logic                     ff_valid,
  output logic [WIDTH-1:0]         ff_a,
  output logic [WIDTH-1:0]         ff_b,
  output logic [2:0]               ff_flags
`endif
);

  localparam int CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  logic [WIDTH-1:0]  idx_q, idx_d;
  logic [CNTW-1:0]   settle_cnt_q, settle_cnt_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [CW-1:0]     err_cnt_q, err_cnt_d;
`ifdef PES_CMP_FIRST_FAIL_EN
  logic              ff_valid_q, ff_valid_d;
  logic [WIDTH-1:0]  ff_a_q, ff_a_d;
  logic [WIDTH-1:0]  ff_b_q, ff_b_d;
  logic [2:0]        ff_flags_q, ff_flags_d;
`endif

  logic [2:0] exp_flags;
  logic [2:0] obs_flags;
  logic       mismatch;
  logic       last_vec;

  // Expected flags come from the operands actually on the bus, so wrapped vectors check correctly
  pes_cmp_golden #(.WIDTH(WIDTH)) u_golden (
    .a     (a_q),
    .b     (b_q),
    .flags (exp_flags)
  );

  assign obs_flags = {cmp.lt_i, cmp.eq_i, cmp.gt_i};
  assign mismatch  = (obs_flags != exp_flags);
  assign last_vec  = (phase_q == GREATER) && (idx_q == '1);

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    idx_d        = idx_q;
    settle_cnt_d = settle_cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    err_cnt_d    = err_cnt_q;
`ifdef PES_CMP_FIRST_FAIL_EN
    ff_valid_d   = ff_valid_q;
    ff_a_d       = ff_a_q;
    ff_b_d       = ff_b_q;
    ff_flags_d   = ff_flags_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // done_q is high only in the IDLE cycle right after DONE; a start there is dropped
        if (start && !done_q) begin
          state_d   = ST_DRIVE;
          phase_d   = LESS;
          idx_d     = '0;
          err_cnt_d = '0;
          busy_d    = 1'b1;
`ifdef PES_CMP_FIRST_FAIL_EN
          ff_valid_d = 1'b0;
          ff_a_d     = '0;
          ff_b_d     = '0;
          ff_flags_d = '0;
`endif
        end
      end

      ST_DRIVE: begin
        case (phase_q)
          LESS: begin
            a_d = idx_q;
            b_d = idx_q + WIDTH'(1);
          end
          GREATER: begin
            a_d = idx_q + WIDTH'(1);
            b_d = idx_q;
          end
          default: begin
            a_d = idx_q;
            b_d = idx_q;
          end
        endcase
        settle_cnt_d = CNTW'(SETTLE - 1);
        state_d      = ST_SETTLE;
      end

      ST_SETTLE: begin
        if (settle_cnt_q == '0) begin
          state_d = ST_CHECK;
        end else begin
          settle_cnt_d = settle_cnt_q - CNTW'(1);
        end
      end

      ST_CHECK: begin
        if (mismatch) begin
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + CW'(1);
          end
`ifdef PES_CMP_FIRST_FAIL_EN
          if (!ff_valid_q) begin
            ff_valid_d = 1'b1;
            ff_a_d     = a_q;
            ff_b_d     = b_q;
            ff_flags_d = obs_flags;
          end
`endif
        end
        if (last_vec) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRIVE;
          idx_d   = idx_q + WIDTH'(1);
          if (idx_q == '1) begin
            phase_d = (phase_q == LESS) ? EQUAL : GREATER;
          end
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        pass_d  = (err_cnt_q == '0);
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      phase_q      <= LESS;
      idx_q        <= '0;
      settle_cnt_q <= '0;
      a_q          <= '0;
      b_q          <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_cnt_q    <= '0;
`ifdef PES_CMP_FIRST_FAIL_EN
      ff_valid_q   <= 1'b0;
      ff_a_q       <= '0;
      ff_b_q       <= '0;
      ff_flags_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      idx_q        <= idx_d;
      settle_cnt_q <= settle_cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_cnt_q    <= err_cnt_d;
`ifdef PES_CMP_FIRST_FAIL_EN
      ff_valid_q   <= ff_valid_d;
      ff_a_q       <= ff_a_d;
      ff_b_q       <= ff_b_d;
      ff_flags_q   <= ff_flags_d;
`endif
    end
  end

  assign cmp.a_o = a_q;
  assign cmp.b_o = b_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_cnt_q;
`ifdef PES_CMP_FIRST_FAIL_EN
  assign ff_valid = ff_valid_q;
  assign ff_a     = ff_a_q;
  assign ff_b     = ff_b_q;
  assign ff_flags = ff_flags_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pes_cmp_sweep_checker.sv
// ---------------------------------------------------------------------------
// tb_pes_cmp_sweep_checker: directed bench with a behavioural comparator in three fault modes
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pes_cmp_sweep_checker;

  localparam int WIDTH  = 2;
  localparam int SETTLE = 2;
  localparam int CW     = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          pass;
  logic [CW-1:0] err_cnt;
`ifdef PES_CMP_FIRST_FAIL_EN
  logic             ff_valid;
  logic [WIDTH-1:0] ff_a;
  logic [WIDTH-1:0] ff_b;
  logic [2:0]       ff_flags;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int mode     = 0;   // 0 correct, 1 eq stuck high, 2 lt/gt swapped

  pes_cmp_sweep_checker_if #(.WIDTH(WIDTH)) cmp_if ();

  pes_cmp_sweep_checker #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .cmp     (cmp_if.master),
    .busy    (busy),
    .done    (done),
    .pass    (pass),
    .err_cnt (err_cnt)
`ifdef PES_CMP_FIRST_FAIL_EN
    ,
    .ff_valid (ff_valid),
    .ff_a     (ff_a),
    .ff_b     (ff_b),
    .ff_flags (ff_flags)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator under test, with selectable faults
  always_comb begin
    cmp_if.lt_i = (cmp_if.a_o < cmp_if.b_o);
    cmp_if.eq_i = (cmp_if.a_o == cmp_if.b_o);
    cmp_if.gt_i = (cmp_if.a_o > cmp_if.b_o);
    if (mode == 1) begin
      cmp_if.lt_i = 1'b0;
      cmp_if.eq_i = 1'b1;
      cmp_if.gt_i = 1'b0;
    end else if (mode == 2) begin
      cmp_if.lt_i = (cmp_if.a_o > cmp_if.b_o);
      cmp_if.gt_i = (cmp_if.a_o < cmp_if.b_o);
    end
  end

  // Hand-computed {A,B} per vector, including the wrapped LESS i=3 and GREATER i=3 pairs
  logic [3:0] exp_vec [12] = '{4'h1, 4'h6, 4'hB, 4'hC,
                               4'h0, 4'h5, 4'hA, 4'hF,
                               4'h4, 4'h9, 4'hE, 4'h3};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start a sweep and follow it to completion; restart pulses land on sweep cycles 10 and 30,
  // and another start is offered in the same cycle as done.
  task automatic run_sweep(input string name, input int exp_err, input bit chk_vec,
                           input bit restart);
    int done_at  = 0;
    int done_cnt = 0;
    int n        = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (n < 120 && !(done_at > 0 && n >= done_at + 3)) begin
      n++;
      @(posedge clk);
      #1;
      start = (restart && (n == 9 || n == 29)) || (done && done_at == 0);
      if (chk_vec && (n % 4 == 3) && (n < 48))
        check($sformatf("%s vec%0d", name, n / 4), {cmp_if.a_o, cmp_if.b_o}, exp_vec[n / 4]);
      if (n == 20) check({name, " busy mid"}, busy, 1'b1);
      if (done) begin
        done_cnt++;
        if (done_at == 0) begin
          done_at = n;
          check({name, " pass"}, pass, (exp_err == 0));
          check({name, " err_cnt"}, err_cnt, exp_err);
          check({name, " busy at done"}, busy, 1'b0);
        end
      end
    end
    start = 1'b0;
    check({name, " done cycle"}, done_at, 49);
    check({name, " done pulses"}, done_cnt, 1);
    check({name, " idle after"}, busy, 1'b0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst a_o", cmp_if.a_o, 0);
    check("rst b_o", cmp_if.b_o, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst pass", pass, 0);
    check("rst err_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    mode = 0;
    run_sweep("clean", 0, 1'b1, 1'b0);
`ifdef PES_CMP_FIRST_FAIL_EN
    check("clean ff_valid", ff_valid, 0);
`endif

    mode = 1;
    run_sweep("eq_stuck", 8, 1'b0, 1'b0);
`ifdef PES_CMP_FIRST_FAIL_EN
    check("ff_valid", ff_valid, 1);
    check("ff_a", ff_a, 0);
    check("ff_b", ff_b, 1);
    check("ff_flags", ff_flags, 3'b010);
`endif

    mode = 2;
    run_sweep("swapped", 8, 1'b0, 1'b0);

    mode = 0;
    run_sweep("restart", 0, 1'b1, 1'b1);

    // Asynchronous reset while vector 5 is on the bus
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (n < 22) begin
      @(posedge clk);
      n++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst a_o", cmp_if.a_o, 0);
    check("midrst b_o", cmp_if.b_o, 0);
    check("midrst busy", busy, 0);
    check("midrst pass", pass, 0);
    check("midrst err_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_sweep("post_rst", 0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
